// File: rtl/tb_uart.sv
// 8N1 UART transceiver acting as the bench-side serial partner of the SoC UART pins.
// Transmit takes a level request on its rising edge; receive strobes each decoded byte.
module tb_uart #(
    parameter int CLKS_PER_BIT = 4167
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_clear_req,
    output logic       ser_tx,
    input  logic       ser_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    state_t      tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        ser_tx_n, tx_busy_n, tx_clear_n;
    logic        tx_start_q;

    state_t      rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic [7:0]  rx_data_n;
    logic        rx_valid_n, rx_err_n;
    logic        ser_rx_p0, ser_rx_p1;

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        ser_tx_n   = ser_tx;
        tx_busy_n  = tx_busy;
        tx_clear_n = 1'b0;
        case (tx_state)
            S_IDLE: begin
                if (tx_start && !tx_start_q) begin
                    tx_state_n = S_START;
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_shift_n = tx_data;
                    ser_tx_n   = 1'b0;
                    tx_busy_n  = 1'b1;
                end
            end
            S_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = S_DATA;
                    tx_cnt_n   = '0;
                    ser_tx_n   = tx_shift[0];
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = S_STOP;
                        ser_tx_n   = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        ser_tx_n   = tx_shift[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = S_IDLE;
                    tx_cnt_n   = '0;
                    tx_busy_n  = 1'b0;
                    tx_clear_n = 1'b1;
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    // History starts high so a request already asserted through reset is not a new edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state     <= S_IDLE;
            tx_cnt       <= '0;
            tx_bit       <= '0;
            tx_shift     <= '0;
            ser_tx       <= 1'b1;
            tx_busy      <= 1'b0;
            tx_clear_req <= 1'b0;
            tx_start_q   <= 1'b1;
        end else begin
            tx_state     <= tx_state_n;
            tx_cnt       <= tx_cnt_n;
            tx_bit       <= tx_bit_n;
            tx_shift     <= tx_shift_n;
            ser_tx       <= ser_tx_n;
            tx_busy      <= tx_busy_n;
            tx_clear_req <= tx_clear_n;
            tx_start_q   <= tx_start;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        rx_err_n   = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (!ser_rx_p1) begin
                    rx_state_n = S_START;
                    rx_cnt_n   = '0;
                end
            end
            S_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = ser_rx_p1 ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {ser_rx_p1, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = S_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_state_n = S_IDLE;
                    rx_cnt_n   = '0;
                    if (ser_rx_p1) begin
                        rx_data_n  = rx_shift;
                        rx_valid_n = 1'b1;
                    end else begin
                        rx_err_n = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    // Two-flop synchronizer on the asynchronous serial input, then the decode registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ser_rx_p0    <= 1'b1;
            ser_rx_p1    <= 1'b1;
            rx_state     <= S_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            ser_rx_p0    <= ser_rx;
            ser_rx_p1    <= ser_rx_p0;
            rx_state     <= rx_state_n;
            rx_cnt       <= rx_cnt_n;
            rx_bit       <= rx_bit_n;
            rx_shift     <= rx_shift_n;
            rx_data      <= rx_data_n;
            rx_valid     <= rx_valid_n;
            rx_frame_err <= rx_err_n;
        end
    end

endmodule

// File: tb/tb_tb_uart.sv
// Directed bench for tb_uart at 16 clocks per bit: reset, TX framing and handshake,
// loopback, RX glitch / framing-error handling, and reset in the middle of a frame.
module tb_tb_uart;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy, tx_clear_req, ser_tx, ser_rx;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err;
    logic       loop_en = 1'b0;
    logic       rx_drv = 1'b1;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int err_cnt = 0;
    int clr_cnt = 0;

    assign ser_rx = loop_en ? ser_tx : rx_drv;

    tb_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_clear_req(tx_clear_req),
        .ser_tx      (ser_tx),
        .ser_rx      (ser_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rx_valid)     rx_cnt++;
        if (rx_frame_err) err_cnt++;
        if (tx_clear_req) clr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Samples ser_tx at each bit midpoint of the frame in flight; optionally drops and
    // re-raises tx_start (with new data) while the frame is still busy.
    task automatic capture_frame(input int poke_at, input logic [7:0] poke_data,
                                 output logic [9:0] bits, output int busy_n, output int lat,
                                 output logic clr_end, output logic clr_after);
        bits = '1; busy_n = 0; lat = -1; clr_end = 1'b0; clr_after = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (tx_busy) begin
                if (busy_n == 0) lat = i;
                busy_n++;
                if ((busy_n - 1) % CPB == CPB / 2 && (busy_n - 1) / CPB < 10)
                    bits[(busy_n - 1) / CPB] = ser_tx;
                if (poke_at != 0 && busy_n == poke_at) tx_start = 1'b0;
                if (poke_at != 0 && busy_n == poke_at + 2) begin
                    tx_data = poke_data;
                    tx_start = 1'b1;
                end
            end else if (busy_n > 0) begin
                clr_end = tx_clear_req;
                @(negedge clock);
                clr_after = tx_clear_req;
                break;
            end
        end
    endtask

    task automatic drive_rx(input logic [9:0] frame);
        for (int k = 0; k < 10; k++) begin
            rx_drv = frame[k];
            repeat (CPB) @(negedge clock);
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset;
        logic any_busy;
        reset = 1'b1; tx_start = 1'b1;
        repeat (4) @(negedge clock);
        checks++; if (ser_tx !== 1'b1) begin errors++; $display("FAIL reset_ser_tx got %b exp 1", ser_tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy got %b exp 0", tx_busy); end
        checks++; if (tx_clear_req !== 1'b0) begin errors++; $display("FAIL reset_clear got %b exp 0", tx_clear_req); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
        checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", rx_frame_err); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
        reset = 1'b0;
        any_busy = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (tx_busy !== 1'b0 || ser_tx !== 1'b1) any_busy = 1'b1;
        end
        checks++; if (any_busy) begin errors++; $display("FAIL reset_held_start got frame exp none"); end
    endtask

    task automatic test_tx_frame;
        logic [9:0] bits; int busy_n, lat; logic c0, c1, any_busy;
        tx_start = 1'b0;
        @(negedge clock);
        tx_data = 8'h41; tx_start = 1'b1;
        capture_frame(0, 8'h00, bits, busy_n, lat, c0, c1);
        checks++; if (lat !== 0) begin errors++; $display("FAIL tx_latency got %0d exp 0", lat); end
        checks++; if (bits !== 10'b1_0100_0001_0) begin errors++; $display("FAIL tx_41_bits got %b exp 1010000010", bits); end
        checks++; if (busy_n !== 10 * CPB) begin errors++; $display("FAIL tx_busy_len got %0d exp %0d", busy_n, 10 * CPB); end
        checks++; if (c0 !== 1'b1) begin errors++; $display("FAIL tx_clear_pulse got %b exp 1", c0); end
        checks++; if (c1 !== 1'b0) begin errors++; $display("FAIL tx_clear_width got %b exp 0", c1); end
        any_busy = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (tx_busy) any_busy = 1'b1;
        end
        checks++; if (any_busy) begin errors++; $display("FAIL tx_no_retrigger got busy exp idle"); end
    endtask

    task automatic test_handshake;
        logic [9:0] bits; int busy_n, lat; logic c0, c1, any_busy;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 400 && tx_busy; i++) @(negedge clock);
        tx_start = 1'b0;
        @(negedge clock);
        tx_data = 8'h0F; tx_start = 1'b1;
        capture_frame(0, 8'h00, bits, busy_n, lat, c0, c1);
        checks++; if (bits !== {1'b1, 8'h0F, 1'b0}) begin errors++; $display("FAIL hs_0F_bits got %b exp %b", bits, {1'b1, 8'h0F, 1'b0}); end
        checks++; if (busy_n !== 10 * CPB || c0 !== 1'b1) begin errors++; $display("FAIL hs_0F_end got busy %0d clr %b exp %0d 1", busy_n, c0, 10 * CPB); end
        tx_start = 1'b0;
        @(negedge clock);
        tx_data = 8'h3D; tx_start = 1'b1;
        capture_frame(50, 8'hAA, bits, busy_n, lat, c0, c1);
        checks++; if (bits !== {1'b1, 8'h3D, 1'b0}) begin errors++; $display("FAIL hs_3D_bits got %b exp %b", bits, {1'b1, 8'h3D, 1'b0}); end
        checks++; if (busy_n !== 10 * CPB || c0 !== 1'b1 || c1 !== 1'b0) begin errors++; $display("FAIL hs_3D_end got busy %0d clr %b%b exp %0d 10", busy_n, c0, c1, 10 * CPB); end
        any_busy = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (tx_busy) any_busy = 1'b1;
        end
        checks++; if (any_busy) begin errors++; $display("FAIL hs_busy_reraise_queued got busy exp idle"); end
        tx_start = 1'b0;
    endtask

    task automatic test_loopback;
        logic [7:0] lb [4] = '{8'h30, 8'h61, 8'hFF, 8'h00};
        logic [9:0] bits; int busy_n, lat; logic c0, c1;
        int base_v, base_e;
        loop_en = 1'b1;
        base_v = rx_cnt; base_e = err_cnt;
        for (int k = 0; k < 4; k++) begin
            tx_start = 1'b0;
            @(negedge clock);
            tx_data = lb[k]; tx_start = 1'b1;
            capture_frame(0, 8'h00, bits, busy_n, lat, c0, c1);
            checks++; if (rx_cnt !== base_v + k + 1) begin errors++; $display("FAIL loop_valid_count got %0d exp %0d", rx_cnt - base_v, k + 1); end
            checks++; if (rx_data !== lb[k]) begin errors++; $display("FAIL loop_rx_data got %h exp %h", rx_data, lb[k]); end
        end
        checks++; if (err_cnt !== base_e) begin errors++; $display("FAIL loop_frame_err got %0d exp 0", err_cnt - base_e); end
        tx_start = 1'b0;
        @(negedge clock);
        loop_en = 1'b0;
    endtask

    task automatic test_rx_err;
        int base_v, base_e;
        base_v = rx_cnt; base_e = err_cnt;
        @(negedge clock);
        rx_drv = 1'b0;
        repeat (3) @(negedge clock);
        rx_drv = 1'b1;
        repeat (40) @(negedge clock);
        checks++; if (rx_cnt !== base_v || err_cnt !== base_e) begin errors++; $display("FAIL rx_glitch got valid %0d err %0d exp 0 0", rx_cnt - base_v, err_cnt - base_e); end
        drive_rx({1'b0, 8'h5A, 1'b0});
        repeat (40) @(negedge clock);
        checks++; if (err_cnt !== base_e + 1) begin errors++; $display("FAIL rx_frame_err got %0d exp 1", err_cnt - base_e); end
        checks++; if (rx_cnt !== base_v) begin errors++; $display("FAIL rx_err_valid got %0d exp 0", rx_cnt - base_v); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rx_err_data got %h exp 00", rx_data); end
        drive_rx({1'b1, 8'hA5, 1'b0});
        repeat (40) @(negedge clock);
        checks++; if (rx_cnt !== base_v + 1) begin errors++; $display("FAIL rx_good_valid got %0d exp 1", rx_cnt - base_v); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL rx_good_data got %h exp a5", rx_data); end
        checks++; if (err_cnt !== base_e + 1) begin errors++; $display("FAIL rx_good_err got %0d exp 1", err_cnt - base_e); end
    endtask

    task automatic test_reset_mid_tx;
        int base_c; logic any_busy;
        tx_start = 1'b0;
        @(negedge clock);
        tx_data = 8'hC3; tx_start = 1'b1;
        repeat (4 * CPB) @(negedge clock);
        checks++; if (tx_busy !== 1'b1 || ser_tx !== 1'b0) begin errors++; $display("FAIL midtx_pre got busy %b ser %b exp 1 0", tx_busy, ser_tx); end
        base_c = clr_cnt;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (ser_tx !== 1'b1) begin errors++; $display("FAIL midtx_ser_tx got %b exp 1", ser_tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL midtx_busy got %b exp 0", tx_busy); end
        @(negedge clock);
        reset = 1'b0;
        any_busy = 1'b0;
        repeat (200) begin
            @(negedge clock);
            if (tx_busy) any_busy = 1'b1;
        end
        checks++; if (clr_cnt !== base_c) begin errors++; $display("FAIL midtx_clear got %0d exp 0", clr_cnt - base_c); end
        checks++; if (any_busy) begin errors++; $display("FAIL midtx_restart got busy exp idle"); end
        tx_start = 1'b0;
    endtask

    initial begin
        test_reset;
        test_tx_frame;
        test_handshake;
        test_loopback;
        test_rx_err;
        test_reset_mid_tx;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
